// File: rtl/diff_histogram_pkg.sv
// Shared definitions for the latency histogram: FSM states, bin indices, the
// compare stage's one-hot latency codes and the word-to-bin classifier.
package diff_histogram_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StScan,
      StHold
   } state_e;

   localparam int unsigned NumBins = 6;

   localparam logic [2:0] BinL1   = 3'd0;
   localparam logic [2:0] BinL2   = 3'd1;
   localparam logic [2:0] BinL3   = 3'd2;
   localparam logic [2:0] BinL4   = 3'd3;
   localparam logic [2:0] BinMiss = 3'd4;
   localparam logic [2:0] BinIll  = 3'd5;

   localparam logic [2:0] BestNone = 3'd4;

   localparam logic [3:0] DiffL1   = 4'b0001;
   localparam logic [3:0] DiffL2   = 4'b0010;
   localparam logic [3:0] DiffL3   = 4'b0100;
   localparam logic [3:0] DiffL4   = 4'b1000;
   localparam logic [3:0] DiffMiss = 4'b0000;

   // Map one compare word to the single bin it increments.
   function automatic logic [2:0] diff_to_bin(input logic [3:0] diff);
      logic [2:0] bin;
      case (diff)
         DiffL1:   bin = BinL1;
         DiffL2:   bin = BinL2;
         DiffL3:   bin = BinL3;
         DiffL4:   bin = BinL4;
         DiffMiss: bin = BinMiss;
         default:  bin = BinIll;
      endcase
      return bin;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for one histogram bin.
//  clk   : clock, posedge
//  rst_n : asynchronous active-low reset, clears the count
//  clr   : synchronous clear, wins over inc
//  inc   : count one event; holds at all-ones instead of wrapping
//  q     : current count
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/diff_histogram.sv
// Latency histogram over a fixed window of one-hot compare words.
// Bins each sample as latency 1..4, miss or illegal, then scans the four
// latency bins for the dominant one and freezes everything for readout.
//  i_clk   : clock, posedge
//  i_rst_n : asynchronous active-low reset
//  i_diff  : one-hot latency word (bit0 = 1 cycle ... bit3 = 4 cycles)
//  i_start : clear bins and begin a new window, accepted in any state
//  i_sel   : readout select, 0-3 latency, 4 miss, 5 illegal, 6/7 zero
//  o_count : registered value of the selected bin (1-cycle latency)
//  o_best  : dominant latency bin 0-3, 4 when the window had no hits
//  o_busy  : window running or scanning
//  o_done  : results valid and frozen
module diff_histogram
   import diff_histogram_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned WIN_LOG2 = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [3:0]       i_diff,
   input  logic             i_start,
   input  logic [2:0]       i_sel,
   output logic [CNT_W-1:0] o_count,
   output logic [2:0]       o_best,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned WinW = WIN_LOG2 + 1;
   localparam logic [WinW-1:0] WinLen = {1'b1, {WIN_LOG2{1'b0}}};

   state_e state_q, state_d;

   logic [WinW-1:0]  win_q, win_d;
   logic [1:0]       scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [1:0]       arg_q, arg_d;
   logic [2:0]       best_q, best_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [CNT_W-1:0] bin_cnt [NumBins];
   logic [2:0]       sample_bin;
   logic             run_sample;
   logic             last_sample;
   logic [CNT_W-1:0] scan_val;

   // The start cycle itself is never sampled.
   assign run_sample  = (state_q == StRun) && !i_start;
   assign last_sample = run_sample && (win_q == WinW'(1));
   assign sample_bin  = diff_to_bin(i_diff);

   for (genvar b = 0; b < NumBins; b++) begin : g_bin
      sat_counter #(
         .W (CNT_W)
      ) u_bin (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .clr   (i_start),
         .inc   (run_sample && (sample_bin == 3'(b))),
         .q     (bin_cnt[b])
      );
   end

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (i_start) begin
         state_d = StRun;
      end else begin
         case (state_q)
            StIdle:  state_d = StIdle;
            StRun:   if (last_sample) state_d = StScan;
            StScan:  if (scan_idx_q == 2'd3) state_d = StHold;
            StHold:  state_d = StHold;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      o_busy = (state_q == StRun) || (state_q == StScan);
      o_done = (state_q == StHold);
   end

   assign scan_val = bin_cnt[{1'b0, scan_idx_q}];

   always_comb begin
      win_d      = win_q;
      scan_idx_d = scan_idx_q;
      max_d      = max_q;
      arg_d      = arg_q;
      best_d     = best_q;
      if (i_start) begin
         win_d      = WinLen;
         scan_idx_d = '0;
         max_d      = '0;
         arg_d      = '0;
         best_d     = BestNone;
      end else begin
         case (state_q)
            StRun: win_d = win_q - WinW'(1);
            StScan: begin
               // Strict compare keeps the lowest index on a tie.
               if (scan_val > max_q) begin
                  max_d = scan_val;
                  arg_d = scan_idx_q;
               end
               scan_idx_d = scan_idx_q + 2'd1;
               if (scan_idx_q == 2'd3) begin
                  best_d = (max_d != '0) ? {1'b0, arg_d} : BestNone;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      count_d = '0;
      if (i_sel < 3'(NumBins)) begin
         count_d = bin_cnt[i_sel];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         win_q      <= '0;
         scan_idx_q <= '0;
         max_q      <= '0;
         arg_q      <= '0;
         best_q     <= BestNone;
         count_q    <= '0;
      end else begin
         win_q      <= win_d;
         scan_idx_q <= scan_idx_d;
         max_q      <= max_d;
         arg_q      <= arg_d;
         best_q     <= best_d;
         count_q    <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_best  = best_q;

endmodule

// File: tb/tb_diff_histogram.sv
module tb_diff_histogram;

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned WIN_LOG2 = 5;
   localparam int          NS       = 1 << WIN_LOG2;
   localparam int          SAT      = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [3:0]       i_diff;
   logic             i_start;
   logic [2:0]       i_sel;
   logic [CNT_W-1:0] o_count;
   logic [2:0]       o_best;
   logic             o_busy;
   logic             o_done;

   diff_histogram #(
      .CNT_W    (CNT_W),
      .WIN_LOG2 (WIN_LOG2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_diff  (i_diff),
      .i_start (i_start),
      .i_sel   (i_sel),
      .o_count (o_count),
      .o_best  (o_best),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_cnt_q[$];
   int exp_best_q[$];
   int model_bins[6];
   logic rd_v = 1'b0;
   logic rd_pend;
   logic done_prev = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: readout values arrive one cycle after the select.
   always @(posedge clk) rd_pend <= rd_v;

   always @(negedge clk) begin
      if (rd_pend === 1'b1) begin
         if (exp_cnt_q.size() == 0) check("count_queue_underflow", 1, 0);
         else check("o_count", int'(o_count), exp_cnt_q.pop_front());
      end
      if (o_done === 1'b1 && done_prev !== 1'b1) begin
         if (exp_best_q.size() == 0) check("best_queue_underflow", 1, 0);
         else check("o_best", int'(o_best), exp_best_q.pop_front());
      end
      done_prev = o_done;
   end

   // Reference model
   function automatic void model_clear();
      for (int i = 0; i < 6; i++) model_bins[i] = 0;
   endfunction

   function automatic void model_sample(input logic [3:0] d);
      int idx;
      if (d == 4'd0) idx = 4;
      else if ($countones(d) == 1) idx = d[0] ? 0 : d[1] ? 1 : d[2] ? 2 : 3;
      else idx = 5;
      if (model_bins[idx] < SAT) model_bins[idx]++;
   endfunction

   function automatic int model_best();
      int best = 4;
      int mx = 0;
      for (int i = 0; i < 4; i++) begin
         if (model_bins[i] > mx) begin
            mx = model_bins[i];
            best = i;
         end
      end
      return best;
   endfunction

   function automatic logic [3:0] gen_diff();
      int r = $urandom_range(0, 5);
      if (r < 4) return 4'(1 << r);
      if (r == 4) return 4'd0;
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      i_start = 1'b1;
      i_diff  = 4'($urandom_range(0, 15));
      model_clear();
      step();
      i_start = 1'b0;
   endtask

   // mode 0: random words, mode 1: constant cval
   task automatic feed(input int n, input int mode, input logic [3:0] cval);
      logic [3:0] d;
      for (int i = 0; i < n; i++) begin
         d = (mode == 0) ? gen_diff() : cval;
         i_diff = d;
         model_sample(d);
         step();
      end
   endtask

   task automatic finish_window();
      int n = 0;
      exp_best_q.push_back(model_best());
      while (o_done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("scan_cycles", n, 4);
      check("hold_busy", int'(o_busy), 0);
   endtask

   task automatic readout();
      for (int s = 0; s < 8; s++) begin
         i_sel = 3'(s);
         exp_cnt_q.push_back((s < 6) ? model_bins[s] : 0);
         rd_v = 1'b1;
         step();
      end
      rd_v = 1'b0;
      step();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] mix[$];
      logic [3:0] tmp;
      int j;
      rst_n = 1'b0;
      i_start = 1'b0;
      i_diff = 4'd0;
      i_sel = 3'd0;
      #12;
      check("rst_count", int'(o_count), 0);
      check("rst_best", int'(o_best), 4);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      i_diff = 4'b0001;
      step();
      step();
      check("idle_busy", int'(o_busy), 0);

      // T1: single latency class
      do_start();
      check("start_busy", int'(o_busy), 1);
      check("start_best", int'(o_best), 4);
      feed(NS, 1, 4'b0010);
      check("scan_busy", int'(o_busy), 1);
      finish_window();
      readout();

      // T2: shuffled mix with a tie between bins 0 and 2
      for (int i = 0; i < 10; i++) begin
         mix.push_back(4'b0001);
         mix.push_back(4'b0100);
      end
      for (int i = 0; i < 6; i++) begin
         mix.push_back(4'b0000);
         mix.push_back(4'b0110);
      end
      for (int i = NS - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = mix[i];
         mix[i] = mix[j];
         mix[j] = tmp;
      end
      do_start();
      foreach (mix[i]) feed(1, 1, mix[i]);
      finish_window();
      check("tie_best", int'(o_best), 0);
      readout();

      // T3: saturation
      do_start();
      feed(NS, 1, 4'b1000);
      finish_window();
      readout();

      // T4: all misses, then inputs change while holding
      do_start();
      feed(NS, 1, 4'b0000);
      finish_window();
      for (int i = 0; i < 5; i++) begin
         i_diff = 4'($urandom_range(0, 15));
         step();
      end
      check("hold_done", int'(o_done), 1);
      readout();

      // T5: restart mid-window
      do_start();
      feed(7, 0, 4'd0);
      do_start();
      feed(NS, 1, 4'b0001);
      finish_window();
      readout();

      // Random windows
      for (int w = 0; w < 5; w++) begin
         do_start();
         feed(NS, 0, 4'd0);
         finish_window();
         readout();
      end

      // T6: async reset during scan
      do_start();
      feed(NS, 1, 4'b0100);
      i_sel = 3'd2;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("arst_count", int'(o_count), 0);
      check("arst_best", int'(o_best), 4);
      check("arst_busy", int'(o_busy), 0);
      check("arst_done", int'(o_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      step();
      check("post_rst_busy", int'(o_busy), 0);
      check("post_rst_done", int'(o_done), 0);
      model_clear();
      readout();

      step();
      check("count_queue_empty", exp_cnt_q.size(), 0);
      check("best_queue_empty", exp_best_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
